// File: rtl/hub_pkg.sv
// Shared limits, the hub cog mask type and the index-width helper used by the hub slot sequencer.
package hub_pkg;
    localparam int MAX_COGS = 16;
    localparam int MAX_DIV  = 16;

    typedef logic [MAX_COGS-1:0] cog_mask_t;

    // A single-cog build still needs a 1-bit index.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/hub_slot_pick.sv
// Rotating priority finder: first set mask bit strictly after cur_idx, cyclic, with cur_idx itself checked last.
// Purely combinational; wrap is set when the chosen index is not above cur_idx.
module hub_slot_pick
    import hub_pkg::*;
#(
    parameter int N  = 8,
    parameter int IW = idx_w(N)
) (
    input  logic [IW-1:0] cur_idx,
    input  cog_mask_t     mask,
    output logic [IW-1:0] next_idx,
    output logic          found,
    output logic          wrap
);
    int j;

    always_comb begin
        next_idx = '0;
        found    = 1'b0;
        wrap     = 1'b0;
        j        = 0;
        for (int i = 1; i <= N; i++) begin
            j = int'(cur_idx) + i;
            if (j >= N) j = j - N;
            if (!found && mask[j]) begin
                found    = 1'b1;
                next_idx = IW'(j);
                wrap     = (j <= int'(cur_idx));
            end
        end
    end
endmodule

// File: rtl/hub_slot_seq.sv
// Hub slot sequencer: ena_bus strobe every DIV cycles, one-hot bus_sel advancing on the strobe, free-running cnt.
// All outputs registered; HUB_SLOT_SKIP_EN compiles in rotation over enabled cogs only.
module hub_slot_seq
    import hub_pkg::*;
#(
    parameter int NUMCOGS = 8,
    parameter int DIV     = 2,
    parameter int CNT_W   = 32,
    parameter int IDX_W   = idx_w(NUMCOGS)
) (
    input  logic               clk_cog,
    input  logic               inp_res,
    input  logic               soft_res,
    input  logic               skip_en,
    input  logic [NUMCOGS-1:0] cog_ena,
    output logic               ena_bus,
    output logic [NUMCOGS-1:0] bus_sel,
    output logic [IDX_W-1:0]   slot_idx,
    output logic               round_start,
    output logic [CNT_W-1:0]   cnt
);
    localparam int DIV_W = idx_w(MAX_DIV);

    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic               ena_bus_q, ena_bus_d;
    logic [NUMCOGS-1:0] bus_sel_q, bus_sel_d;
    logic [IDX_W-1:0]   slot_idx_q, slot_idx_d;
    logic               round_start_q, round_start_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               idle;
    logic [IDX_W-1:0]   strict_idx;
    logic [IDX_W-1:0]   nxt_idx;
    logic               nxt_found;
    logic               nxt_wrap;

    assign idle = (bus_sel_q == '0);

    always_comb begin
        strict_idx = '0;
        if (!idle && slot_idx_q != IDX_W'(NUMCOGS - 1)) strict_idx = slot_idx_q + IDX_W'(1);
    end

`ifdef HUB_SLOT_SKIP_EN
    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;
    logic             pick_wrap;
    logic [IDX_W-1:0] pick_cur;

    // Starting from the last index makes index 0 the first candidate out of idle.
    assign pick_cur = idle ? IDX_W'(NUMCOGS - 1) : slot_idx_q;

    hub_slot_pick #(.N(NUMCOGS), .IW(IDX_W)) u_pick (
        .cur_idx  (pick_cur),
        .mask     (cog_mask_t'(cog_ena)),
        .next_idx (pick_idx),
        .found    (pick_found),
        .wrap     (pick_wrap)
    );

    always_comb begin
        nxt_idx   = strict_idx;
        nxt_found = 1'b1;
        nxt_wrap  = (strict_idx <= slot_idx_q);
        if (skip_en) begin
            nxt_idx   = pick_idx;
            nxt_found = pick_found;
            nxt_wrap  = pick_wrap;
        end
    end
`else
    logic unused_skip;
    assign unused_skip = ^{skip_en, cog_ena};

    assign nxt_idx   = strict_idx;
    assign nxt_found = 1'b1;
    assign nxt_wrap  = (strict_idx <= slot_idx_q);
`endif

    always_comb begin
        cnt_d         = cnt_q + CNT_W'(1);
        div_cnt_d     = (div_cnt_q == DIV_W'(DIV - 1)) ? '0 : div_cnt_q + DIV_W'(1);
        ena_bus_d     = (div_cnt_q == '0);
        bus_sel_d     = bus_sel_q;
        slot_idx_d    = slot_idx_q;
        round_start_d = round_start_q;
        // Slot ownership only moves on the registered strobe, so each slot lasts DIV cycles.
        if (ena_bus_q) begin
            bus_sel_d     = nxt_found ? (NUMCOGS'(1) << nxt_idx) : '0;
            slot_idx_d    = nxt_found ? nxt_idx : '0;
            round_start_d = nxt_found && (idle || nxt_wrap);
        end
        if (soft_res) begin
            div_cnt_d     = '0;
            ena_bus_d     = 1'b0;
            bus_sel_d     = '0;
            slot_idx_d    = '0;
            round_start_d = 1'b0;
        end
    end

    always_ff @(posedge clk_cog) begin
        if (inp_res) begin
            div_cnt_q     <= '0;
            ena_bus_q     <= 1'b0;
            bus_sel_q     <= '0;
            slot_idx_q    <= '0;
            round_start_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            ena_bus_q     <= ena_bus_d;
            bus_sel_q     <= bus_sel_d;
            slot_idx_q    <= slot_idx_d;
            round_start_q <= round_start_d;
            cnt_q         <= cnt_d;
        end
    end

    assign ena_bus     = ena_bus_q;
    assign bus_sel     = bus_sel_q;
    assign slot_idx    = slot_idx_q;
    assign round_start = round_start_q;
    assign cnt         = cnt_q;
endmodule
